button_debounce: RTL and testbench



---
 rtl/button_pkg.sv | 16 +
 rtl/sync2.sv | 23 ++
 rtl/button_debounce.sv | 139 +++++++++++++
 tb/tb_button_debounce.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/button_pkg.sv
// Shared types and helpers for the push-button conditioning block.
package button_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_t;

  // Width of a counter that must hold values up to n without wrapping.
  function automatic int cnt_width(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for an asynchronous input pin; reset value is configurable.
module sync2 #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic pin_clk_16M,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge pin_clk_16M) begin
    if (!reset_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/button_debounce.sv
// Push-button conditioner: synchronise, debounce, emit level, press/release/long pulses and a saturating press count.
// Optional auto-repeat of btn_press while held is enabled by defining BUTTON_AUTOREPEAT_EN.
module button_debounce
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = 160000,
  parameter int LONG_PRESS_CYCLES = 16000000,
  parameter int REPEAT_CYCLES     = 4000000,
  parameter int ACTIVE_HIGH       = 1,
  parameter int COUNT_W           = 8
) (
  input  logic               pin_clk_16M,
  input  logic               reset_n,
  input  logic               pin_button1,
  output logic               btn_level,
  output logic               btn_press,
  output logic               btn_release,
  output logic               btn_long,
  output logic [COUNT_W-1:0] press_count,
  output btn_state_t         state_dbg
);

  localparam int DW = cnt_width(DEBOUNCE_CYCLES);
  localparam int LW = cnt_width(LONG_PRESS_CYCLES);
  localparam logic INACTIVE = (ACTIVE_HIGH != 0) ? 1'b0 : 1'b1;
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [LW-1:0] LP_LAST = LW'(LONG_PRESS_CYCLES - 1);
  localparam logic [LW-1:0] LP_PRE  = LW'(LONG_PRESS_CYCLES - 2);
  localparam logic [COUNT_W-1:0] COUNT_MAX = {COUNT_W{1'b1}};

  btn_state_t    state;
  logic          pin_sync;
  logic          act_q;
  logic [DW-1:0] cnt;
  logic [LW-1:0] hold_cnt;

`ifdef BUTTON_AUTOREPEAT_EN
  localparam int RW = cnt_width(REPEAT_CYCLES);
  localparam logic [RW-1:0] RP_LAST = RW'(REPEAT_CYCLES - 1);
  logic [RW-1:0] rep_cnt;
`endif

  sync2 #(.RESET_VAL(INACTIVE)) u_sync (
    .pin_clk_16M (pin_clk_16M),
    .reset_n     (reset_n),
    .d           (pin_button1),
    .q           (pin_sync)
  );

  assign state_dbg = state;

  always_ff @(posedge pin_clk_16M) begin
    if (!reset_n) begin
      act_q       <= 1'b0;
      state       <= IDLE;
      cnt         <= '0;
      hold_cnt    <= '0;
      btn_level   <= 1'b0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
      btn_long    <= 1'b0;
      press_count <= '0;
`ifdef BUTTON_AUTOREPEAT_EN
      rep_cnt     <= '0;
`endif
    end else begin
      // Polarity-normalised level: 1 always means pressed from here on.
      act_q       <= pin_sync ^ INACTIVE;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
      btn_long    <= 1'b0;
      case (state)
        IDLE: begin
          if (act_q) begin
            state <= PRESS_WAIT;
            cnt   <= DW'(1);
          end
        end
        PRESS_WAIT: begin
          if (!act_q) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == DB_LAST) begin
            state     <= HELD;
            cnt       <= '0;
            hold_cnt  <= '0;
            btn_press <= 1'b1;
            btn_level <= 1'b1;
            if (press_count != COUNT_MAX) press_count <= press_count + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HELD: begin
          // Saturating at the long-press point makes btn_long fire once per press.
          if (hold_cnt != LP_LAST) begin
            hold_cnt <= hold_cnt + 1'b1;
            if (hold_cnt == LP_PRE) btn_long <= 1'b1;
          end
          if (!act_q) begin
            state <= RELEASE_WAIT;
            cnt   <= DW'(1);
          end
        end
        RELEASE_WAIT: begin
          if (act_q) begin
            state <= HELD;
            cnt   <= '0;
          end else if (cnt == DB_LAST) begin
            state       <= IDLE;
            cnt         <= '0;
            btn_release <= 1'b1;
            btn_level   <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
`ifdef BUTTON_AUTOREPEAT_EN
      if (state == HELD && hold_cnt == LP_LAST) begin
        if (rep_cnt == RP_LAST) begin
          rep_cnt   <= '0;
          btn_press <= 1'b1;
          if (press_count != COUNT_MAX) press_count <= press_count + 1'b1;
        end else begin
          rep_cnt <= rep_cnt + 1'b1;
        end
      end else begin
        rep_cnt <= '0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_button_debounce.sv
// Self-checking bench for button_debounce: sample-window reference model plus directed latency/boundary checks.
module tb_button_debounce;
  import button_pkg::*;

  localparam int D  = 4;
  localparam int L  = 20;
  localparam int R  = 8;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          pin = 1'b0;
  logic          btn_level, btn_press, btn_release, btn_long;
  logic [CW-1:0] press_count;
  btn_state_t    state_dbg;

  int checks = 0;
  int errors = 0;

  button_debounce #(
    .DEBOUNCE_CYCLES   (D),
    .LONG_PRESS_CYCLES (L),
    .REPEAT_CYCLES     (R),
    .ACTIVE_HIGH       (1),
    .COUNT_W           (CW)
  ) dut (
    .pin_clk_16M (clk),
    .reset_n     (reset_n),
    .pin_button1 (pin),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release),
    .btn_long    (btn_long),
    .press_count (press_count),
    .state_dbg   (state_dbg)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Reference model: a press is accepted once D consecutive pin samples, seen
  // through a 3-edge input pipeline, agree; release likewise. Hold time counts
  // edges whose delayed sample shows the button down while pressed.
  logic [7:0]    hist;
  bit            m_pressed, m_press, m_release, m_long, m_held, model_on;
  int            m_hold, m_count, m_rep;
  logic [CW-1:0] exp_q[$];

  always @(posedge clk) begin
    m_press   = 1'b0;
    m_release = 1'b0;
    m_long    = 1'b0;
    if (!reset_n) begin
      hist      = '0;
      m_pressed = 1'b0;
      m_hold    = 0;
      m_count   = 0;
      m_rep     = 0;
      model_on  = 1'b1;
    end else begin
      hist   = {hist[6:0], pin};
      m_held = m_pressed && hist[4];
      if (!m_pressed && (&hist[6:3])) begin
        m_pressed = 1'b1;
        m_press   = 1'b1;
        m_hold    = 0;
        if (m_count < 255) m_count++;
        exp_q.push_back(CW'(m_count));
      end else if (m_pressed && !(|hist[6:3])) begin
        m_pressed = 1'b0;
        m_release = 1'b1;
      end else if (m_held) begin
`ifdef BUTTON_AUTOREPEAT_EN
        if (m_hold == L - 1) begin
          m_rep++;
          if (m_rep == R) begin
            m_rep   = 0;
            m_press = 1'b1;
            if (m_count < 255) m_count++;
            exp_q.push_back(CW'(m_count));
          end
        end
`endif
        if (m_hold < L - 1) begin
          m_hold++;
          if (m_hold == L - 1) m_long = 1'b1;
        end
      end
      if (!m_held) m_rep = 0;
    end
  end

  // Scoreboard: every cycle after the first reset edge
  always @(negedge clk) begin
    logic [CW-1:0] e;
    if (model_on) begin
      chk("level",   btn_level,   m_pressed);
      chk("press",   btn_press,   m_press);
      chk("release", btn_release, m_release);
      chk("long",    btn_long,    m_long);
      chk("count",   press_count, m_count);
      if (btn_press === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("press_unexpected", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("count_at_press", press_count, e);
        end
      end
    end
  end

  // Driver tasks (called at a negedge)
  task automatic drive(input logic v, input int n);
    pin = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_pulse(input int which, input int max, output int n);
    n = 0;
    for (int i = 1; i <= max; i++) begin
      @(posedge clk);
      @(negedge clk);
      n = i;
      if ((which == 0 && btn_press === 1'b1) || (which == 1 && btn_release === 1'b1)) return;
    end
    checks++;
    errors++;
    $display("FAIL wait_pulse_%0d: no pulse within %0d cycles", which, max);
    n = max + 1;
  endtask

  initial begin
    int n, first_long, n_long;

    // Reset with the pin already held down
    pin = 1'b1;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_level", btn_level, 0);
    chk("reset_press", btn_press, 0);
    chk("reset_count", press_count, 0);
    chk("reset_state", state_dbg, IDLE);
    reset_n = 1'b1;
    wait_pulse(0, 20, n);
    chk("reset_release_press_latency", n, 7);
    chk("first_press_count", press_count, 1);

    // Clean release then clean press
    pin = 1'b0;
    wait_pulse(1, 20, n);
    chk("release_latency", n, 7);
    chk("level_after_release", btn_level, 0);
    drive(0, 5);
    pin = 1'b1;
    wait_pulse(0, 20, n);
    chk("press_latency", n, 7);
    chk("level_after_press", btn_level, 1);
    drive(1, 3);
    drive(0, 12);

    // Bounce shorter than the debounce window
    drive(1, 3);
    drive(0, 1);
    drive(1, 3);
    drive(0, 12);
    chk("bounce_count", press_count, 2);
    chk("bounce_level", btn_level, 0);

    // Release glitch while held
    drive(1, 10);
    drive(0, 2);
    drive(1, 10);
    chk("glitch_level", btn_level, 1);
    chk("glitch_count", press_count, 3);
    drive(0, 12);

    // Long hold
    pin = 1'b1;
    wait_pulse(0, 20, n);
    first_long = 0;
    n_long = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (btn_long === 1'b1) begin
        n_long++;
        if (first_long == 0) first_long = i;
      end
    end
    chk("long_delay", first_long, 19);
    chk("long_once", n_long, 1);
    drive(0, 12);

    // Press-count saturation
    for (int i = 0; i < 260; i++) begin
      drive(1, 10);
      drive(0, 10);
    end
    chk("count_saturated", press_count, 255);

    // Reset while held, button stays down through reset
    drive(1, 12);
    chk("held_before_reset", btn_level, 1);
    reset_n = 1'b0;
    @(negedge clk);
    chk("midreset_level", btn_level, 0);
    chk("midreset_press", btn_press, 0);
    chk("midreset_release", btn_release, 0);
    chk("midreset_long", btn_long, 0);
    chk("midreset_count", press_count, 0);
    reset_n = 1'b1;
    wait_pulse(0, 20, n);
    chk("post_reset_press_latency", n, 7);
    chk("post_reset_count", press_count, 1);
    drive(0, 12);

    chk("exp_q_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
